// File: rtl/jtag_drv_pkg.sv
// Shared encodings for the on-chip JTAG master: command ops, FSM states and TMS preambles.
// Optional build macro used by the driver: JTAG_DRV_COMPARE_EN (TDO compare against expected/mask).
package jtag_drv_pkg;

    typedef enum logic [1:0] {
        OP_RESET    = 2'b00,
        OP_SHIFT_IR = 2'b01,
        OP_SHIFT_DR = 2'b10,
        OP_IDLE     = 2'b11
    } jtag_op_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE_RDY,
        ST_RUN,
        ST_RSP
    } drv_state_e;

    localparam int         TLR_TCKS = 5;
    // TMS preambles/postamble, LSB goes out first
    localparam logic [3:0] IR_PRE   = 4'b0011;
    localparam logic [2:0] DR_PRE   = 3'b001;
    localparam logic [1:0] POST     = 2'b01;

    function automatic logic is_shift(jtag_op_e op);
        return (op == OP_SHIFT_IR) || (op == OP_SHIFT_DR);
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCLK divider: TCK_DIV CK cycles low then TCK_DIV high while enabled; idles low otherwise.
// Strobes: fall = first low cycle, samp = last low cycle, end = last high cycle.
module jtag_tck_gen #(
    parameter int TCK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tck_o,
    output logic fall_stb_o,
    output logic samp_stb_o,
    output logic end_stb_o
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic          phase_q;
    logic [CW-1:0] cnt_q;
    logic          last_q;

    assign last_q = (cnt_q == CW'(TCK_DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 1'b0;
            cnt_q   <= '0;
        end else if (!en_i) begin
            phase_q <= 1'b0;
            cnt_q   <= '0;
        end else if (last_q) begin
            phase_q <= ~phase_q;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    assign tck_o      = phase_q;
    assign fall_stb_o = en_i && !phase_q && (cnt_q == '0);
    assign samp_stb_o = en_i && !phase_q && last_q;
    assign end_stb_o  = en_i &&  phase_q && last_q;

endmodule

// File: rtl/jtag_tap_driver.sv
// On-chip JTAG master: turns RESET/SHIFT_IR/SHIFT_DR/IDLE commands into TCLK/TMS/TDI and captures TDO.
// Define JTAG_DRV_COMPARE_EN to add masked compare of captured TDO against cmd_exp (rsp_fail).
module jtag_tap_driver
    import jtag_drv_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7,
    parameter int TCK_DIV = 1
) (
    input  logic               CK,
    input  logic               TRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    input  logic [MAX_LEN-1:0] cmd_exp,
    input  logic [MAX_LEN-1:0] cmd_mask,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_fail,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);

    localparam int IW = LEN_W + 1;
    localparam int BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    drv_state_e         state_q;
    jtag_op_e           op_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap_q;
    logic [IW-1:0]      idx_q;
    logic [IW-1:0]      total_q;
    logic               tms_q, tdi_q, shift_q;
    logic [BW-1:0]      bit_q;
    logic               cmd_ready_q, rsp_valid_q, rsp_fail_q;
    logic [MAX_LEN-1:0] rsp_data_q;

    logic gen_en, fall_stb, samp_stb, end_stb;

    assign gen_en = (state_q == ST_INIT) || (state_q == ST_RUN);

    jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
        .clk_i      (CK),
        .rst_ni     (TRST),
        .en_i       (gen_en),
        .tck_o      (tck_o),
        .fall_stb_o (fall_stb),
        .samp_stb_o (samp_stb),
        .end_stb_o  (end_stb)
    );

    // The sequencer evaluates TCLK k of either the incoming command (on handshake,
    // k=0) or the latched one (at the end of each TCLK, k = TCLKs started so far).
    logic               hs;
    logic [LEN_W-1:0]   len_c;
    jtag_op_e           ev_op;
    logic [LEN_W-1:0]   ev_len;
    logic [MAX_LEN-1:0] ev_data;
    logic [IW-1:0]      ev_k;

    assign hs      = (state_q == ST_IDLE_RDY) && cmd_valid;
    assign len_c   = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign ev_op   = hs ? jtag_op_e'(cmd_op) : op_q;
    assign ev_len  = hs ? len_c : len_q;
    assign ev_data = hs ? cmd_data : data_q;
    assign ev_k    = hs ? '0 : idx_q;

    logic [IW-1:0] pre_n, shift_end, nx_total;
    logic [3:0]    pre_pat;
    logic          nx_tms, nx_tdi, nx_shift;
    logic [BW-1:0] nx_bit;

    always_comb begin
        pre_n     = (ev_op == OP_SHIFT_IR) ? IW'(4) : IW'(3);
        pre_pat   = (ev_op == OP_SHIFT_IR) ? IR_PRE : {1'b0, DR_PRE};
        shift_end = pre_n + IW'(ev_len);
        nx_tms    = 1'b0;
        nx_tdi    = 1'b0;
        nx_shift  = 1'b0;
        nx_bit    = '0;
        nx_total  = '0;
        unique case (ev_op)
            OP_RESET: begin
                nx_tms   = (ev_k < IW'(TLR_TCKS));
                nx_total = IW'(TLR_TCKS + 1);
            end
            OP_IDLE: nx_total = IW'(ev_len);
            default: begin
                nx_total = (ev_len == '0) ? '0 : shift_end + IW'(2);
                if (ev_k < pre_n) begin
                    nx_tms = pre_pat[ev_k[1:0]];
                end else if (ev_k < shift_end) begin
                    nx_shift = 1'b1;
                    nx_bit   = BW'(ev_k - pre_n);
                    nx_tdi   = ev_data[nx_bit];
                    nx_tms   = (ev_k == shift_end - IW'(1));
                end else begin
                    // postamble offset is 0 or 1, so its LSB is the xor of the LSBs
                    nx_tms = POST[ev_k[0] ^ shift_end[0]];
                end
            end
        endcase
    end

    logic cmp_fail;

`ifdef JTAG_DRV_COMPARE_EN
    logic [MAX_LEN-1:0] exp_q, mask_q, lenmask;

    assign lenmask  = (len_q >= LEN_W'(MAX_LEN)) ? '1
                    : ((MAX_LEN'(1) << len_q) - MAX_LEN'(1));
    assign cmp_fail = is_shift(op_q) && (|((cap_q ^ exp_q) & mask_q & lenmask));

    always_ff @(posedge CK or negedge TRST) begin
        if (!TRST) begin
            exp_q  <= '0;
            mask_q <= '0;
        end else if (hs) begin
            exp_q  <= cmd_exp;
            mask_q <= cmd_mask;
        end
    end
`else
    logic unused_cmp;
    assign unused_cmp = ^{cmd_exp, cmd_mask};
    assign cmp_fail   = 1'b0;
`endif

    always_ff @(posedge CK or negedge TRST) begin
        if (!TRST) begin
            state_q     <= ST_INIT;
            op_q        <= OP_RESET;
            len_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            idx_q       <= '0;
            total_q     <= IW'(TLR_TCKS + 1);
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            shift_q     <= 1'b0;
            bit_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fail_q  <= 1'b0;
        end else begin
            if (samp_stb && shift_q) cap_q[bit_q] <= tdo_i;
            if (fall_stb) idx_q <= idx_q + IW'(1);
            unique case (state_q)
                ST_INIT, ST_RUN: begin
                    if (end_stb) begin
                        if (idx_q == total_q) begin
                            tms_q   <= 1'b0;
                            tdi_q   <= 1'b0;
                            shift_q <= 1'b0;
                            if (state_q == ST_INIT) begin
                                state_q     <= ST_IDLE_RDY;
                                cmd_ready_q <= 1'b1;
                            end else begin
                                state_q     <= ST_RSP;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= cap_q;
                                rsp_fail_q  <= cmp_fail;
                            end
                        end else begin
                            tms_q   <= nx_tms;
                            tdi_q   <= nx_tdi;
                            shift_q <= nx_shift;
                            bit_q   <= nx_bit;
                        end
                    end
                end
                ST_IDLE_RDY: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= jtag_op_e'(cmd_op);
                        len_q       <= len_c;
                        data_q      <= cmd_data;
                        idx_q       <= '0;
                        cap_q       <= '0;
                        total_q     <= nx_total;
                        if (nx_total == '0) begin
                            // zero-length shift or idle: answer without touching the TAP
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_fail_q  <= 1'b0;
                        end else begin
                            state_q <= ST_RUN;
                            tms_q   <= nx_tms;
                            tdi_q   <= nx_tdi;
                            shift_q <= nx_shift;
                            bit_q   <= nx_bit;
                        end
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE_RDY;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_fail  = rsp_fail_q;
    assign tms_o     = tms_q;
    assign tdi_o     = tdi_q;

endmodule
